// File: rtl/cfo_corr_pkg.sv
// -----------------------------------------------------------------------------
// cfo_corr_pkg
// Shared definitions for the CFO correction datapath.
//   - default widths for cfo_correction / sincos_lut parameters
//   - quadrant_t : NCO phase quadrant (top two phase bits)
//   - sat_trunc(): clamp a signed value to a w-bit two's complement range
// No ports (package).
// -----------------------------------------------------------------------------
package cfo_corr_pkg;

    localparam int CFO_IN_DW  = 32;
    localparam int CFO_OUT_DW = 32;
    localparam int CFO_DDS_DW = 20;
    localparam int CFO_SIN_DW = 16;
    localparam int CFO_LUT_AW = 8;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    // Caller narrows the result to w bits; the clamp guarantees no wrap.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] x,
                                                     input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/cfo_correction_sincos_lut.sv
// -----------------------------------------------------------------------------
// sincos_lut
// Quarter-wave sine ROM with quadrant fold; one registered {sin, cos} output.
// Ports:
//   clk_i    in   clock
//   reset_i  in   asynchronous, active-high reset
//   phase_i  in   [LUT_AW+1:0] {quadrant, quarter-wave address}
//   sin_o    out  signed SIN_DW, sin(phase), registered
//   cos_o    out  signed SIN_DW, cos(phase), registered
// -----------------------------------------------------------------------------
module sincos_lut
    import cfo_corr_pkg::*;
#(
    parameter int SIN_DW = CFO_SIN_DW,
    parameter int LUT_AW = CFO_LUT_AW
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [LUT_AW+1:0]        phase_i,
    output logic signed [SIN_DW-1:0] sin_o,
    output logic signed [SIN_DW-1:0] cos_o
);

    localparam int  DEPTH   = 2 ** LUT_AW;
    localparam real AMP     = real'(2 ** (SIN_DW - 1) - 1);
    localparam real HALF_PI = 1.5707963267948966;

    // Entry i holds AMP*sin(i/DEPTH * pi/2), rounded. The table is a set of
    // elaboration-time constants, so it maps to a ROM without an init block.
    logic signed [SIN_DW-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int VAL = $rtoi(AMP * $sin(HALF_PI * real'(i) / real'(DEPTH)) + 0.5);
        assign rom[i] = SIN_DW'(VAL);
    end

    quadrant_t                quad;
    logic [LUT_AW-1:0]        addr;
    logic signed [SIN_DW-1:0] s_raw;
    logic signed [SIN_DW-1:0] c_raw;
    logic signed [SIN_DW-1:0] sin_n;
    logic signed [SIN_DW-1:0] cos_n;

    assign quad  = quadrant_t'(phase_i[LUT_AW+1 -: 2]);
    assign addr  = phase_i[LUT_AW-1:0];
    // cos comes from the mirrored address (~a == DEPTH-1-a).
    assign s_raw = rom[addr];
    assign c_raw = rom[~addr];

    // Table values never reach -2^(SIN_DW-1), so negation cannot overflow.
    always_comb begin
        sin_n = s_raw;
        cos_n = c_raw;
        unique case (quad)
            Q0: begin sin_n = s_raw;  cos_n = c_raw;  end
            Q1: begin sin_n = c_raw;  cos_n = -s_raw; end
            Q2: begin sin_n = -s_raw; cos_n = -c_raw; end
            Q3: begin sin_n = -c_raw; cos_n = s_raw;  end
            default: begin sin_n = s_raw; cos_n = c_raw; end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sin_o <= '0;
            cos_o <= '0;
        end else begin
            sin_o <= sin_n;
            cos_o <= cos_n;
        end
    end

endmodule

// File: rtl/cfo_correction.sv
// -----------------------------------------------------------------------------
// cfo_correction
// Removes carrier frequency offset: each IQ sample is rotated by
// exp(-j*phase), phase advancing by the loaded DDS increment per sample.
// Fixed latency: sample accepted on edge k -> output valid after edge k+4.
// Ports:
//   clk_i              in   clock
//   reset_i            in   asynchronous, active-high reset
//   s_axis_in_tdata    in   IN_DW  {im, re} signed input sample
//   s_axis_in_tvalid   in   sample valid (always accepted)
//   CFO_DDS_inc_i      in   DDS_DW signed phase increment per sample
//   CFO_valid_i        in   strobe, loads CFO_DDS_inc_i
//   m_axis_out_tdata   out  OUT_DW {im, re} corrected sample
//   m_axis_out_tvalid  out  output valid
//   phase_o            out  DDS_DW current phase accumulator
// Build option:
//   CFO_CORR_PHASE_RESET_EN - an increment strobe also clears the phase
//   accumulator; otherwise phase stays continuous across increment updates.
// -----------------------------------------------------------------------------
module cfo_correction
    import cfo_corr_pkg::*;
#(
    parameter int IN_DW  = CFO_IN_DW,
    parameter int OUT_DW = CFO_OUT_DW,
    parameter int DDS_DW = CFO_DDS_DW,
    parameter int SIN_DW = CFO_SIN_DW,
    parameter int LUT_AW = CFO_LUT_AW
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [IN_DW-1:0]  s_axis_in_tdata,
    input  logic              s_axis_in_tvalid,
    input  logic [DDS_DW-1:0] CFO_DDS_inc_i,
    input  logic              CFO_valid_i,
    output logic [OUT_DW-1:0] m_axis_out_tdata,
    output logic              m_axis_out_tvalid,
    output logic [DDS_DW-1:0] phase_o
);

    localparam int HW_IN  = IN_DW / 2;
    localparam int HW_OUT = OUT_DW / 2;
    localparam int PW     = HW_IN + SIN_DW;
    localparam int SW     = PW + 1;

    logic [DDS_DW-1:0]        inc_reg;
    logic [DDS_DW-1:0]        phase_acc;
    logic                     s0_valid, s1_valid, s2_valid, s3_valid;
    logic [LUT_AW+1:0]        s0_phase;
    logic signed [HW_IN-1:0]  s0_re, s0_im, s1_re, s1_im;
    logic signed [SIN_DW-1:0] lut_sin, lut_cos;
    logic signed [PW-1:0]     p_rc, p_is, p_ic, p_rs;
    logic signed [SW-1:0]     s3_re, s3_im;
    logic signed [HW_OUT-1:0] sat_re, sat_im;

    assign phase_o = phase_acc;

    // A sample on the strobe edge still advances by the old increment.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            inc_reg   <= '0;
            phase_acc <= '0;
        end else begin
            if (CFO_valid_i) begin
                inc_reg <= CFO_DDS_inc_i;
            end
`ifdef CFO_CORR_PHASE_RESET_EN
            if (CFO_valid_i) begin
                phase_acc <= '0;
            end else if (s_axis_in_tvalid) begin
                phase_acc <= phase_acc + inc_reg;
            end
`else
            if (s_axis_in_tvalid) begin
                phase_acc <= phase_acc + inc_reg;
            end
`endif
        end
    end

    // Stage 0: tag the sample; only the bits that address the LUT are kept.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s0_valid <= 1'b0;
            s0_phase <= '0;
            s0_re    <= '0;
            s0_im    <= '0;
        end else begin
            s0_valid <= s_axis_in_tvalid;
            if (s_axis_in_tvalid) begin
                s0_phase <= phase_acc[DDS_DW-1 -: LUT_AW+2];
                s0_re    <= $signed(s_axis_in_tdata[HW_IN-1:0]);
                s0_im    <= $signed(s_axis_in_tdata[IN_DW-1 -: HW_IN]);
            end
        end
    end

    sincos_lut #(
        .SIN_DW (SIN_DW),
        .LUT_AW (LUT_AW)
    ) u_sincos_lut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .phase_i (s0_phase),
        .sin_o   (lut_sin),
        .cos_o   (lut_cos)
    );

    // Stages 1-3: align data with the LUT, multiply, combine and rescale.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s2_valid <= 1'b0;
            p_rc     <= '0;
            p_is     <= '0;
            p_ic     <= '0;
            p_rs     <= '0;
            s3_valid <= 1'b0;
            s3_re    <= '0;
            s3_im    <= '0;
        end else begin
            s1_valid <= s0_valid;
            s1_re    <= s0_re;
            s1_im    <= s0_im;

            s2_valid <= s1_valid;
            p_rc     <= PW'(s1_re) * PW'(lut_cos);
            p_is     <= PW'(s1_im) * PW'(lut_sin);
            p_ic     <= PW'(s1_im) * PW'(lut_cos);
            p_rs     <= PW'(s1_re) * PW'(lut_sin);

            // One guard bit keeps the sum exact before the rescale.
            s3_valid <= s2_valid;
            s3_re    <= (SW'(p_rc) + SW'(p_is)) >>> (SIN_DW - 1);
            s3_im    <= (SW'(p_ic) - SW'(p_rs)) >>> (SIN_DW - 1);
        end
    end

    always_comb begin
        sat_re = HW_OUT'(sat_trunc(64'(s3_re), HW_OUT));
        sat_im = HW_OUT'(sat_trunc(64'(s3_im), HW_OUT));
    end

    // Stage 4: output data holds its last value while valid is low.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            m_axis_out_tdata  <= '0;
            m_axis_out_tvalid <= 1'b0;
        end else begin
            m_axis_out_tvalid <= s3_valid;
            if (s3_valid) begin
                m_axis_out_tdata <= {sat_im, sat_re};
            end
        end
    end

endmodule

// File: tb/tb_cfo_correction.sv
// -----------------------------------------------------------------------------
// tb_cfo_correction
// Directed stimulus for cfo_correction; expected outputs are queued when a
// sample is driven and popped by a monitor whenever the output is valid.
// Expected values come from the quarter-wave table: at a quadrant boundary
// the table gives sin=0, cos=32766, so 8192 -> 8192*32766>>15 = 8191 (or
// -8192 when negated, as the shift floors).
// -----------------------------------------------------------------------------
module tb_cfo_correction;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] s_axis_in_tdata;
    logic        s_axis_in_tvalid;
    logic [19:0] CFO_DDS_inc_i;
    logic        CFO_valid_i;
    logic [31:0] m_axis_out_tdata;
    logic        m_axis_out_tvalid;
    logic [19:0] phase_o;

    cfo_correction dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .s_axis_in_tdata   (s_axis_in_tdata),
        .s_axis_in_tvalid  (s_axis_in_tvalid),
        .CFO_DDS_inc_i     (CFO_DDS_inc_i),
        .CFO_valid_i       (CFO_valid_i),
        .m_axis_out_tdata  (m_axis_out_tdata),
        .m_axis_out_tvalid (m_axis_out_tvalid),
        .phase_o           (phase_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int    re;
        int    im;
        int    edge_n;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Output for quadrant index 0..3 when rotating (8192, 0) by -q*pi/2.
    int q_re[4] = '{8191, 0, -8192, 0};
    int q_im[4] = '{0, -8192, 0, 8191};

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req, input int tol);
        total++;
        if (act > req + tol || act < req - tol) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, req, tol);
        end
    endtask

    task automatic send(input int re, input int im, input int ere, input int eim, input string name);
        exp_t e;
        s_axis_in_tdata  = {16'(im), 16'(re)};
        s_axis_in_tvalid = 1'b1;
        e.re     = ere;
        e.im     = eim;
        e.edge_n = cyc + 1;
        e.name   = name;
        exp_q.push_back(e);
        @(negedge clk_i);
        s_axis_in_tvalid = 1'b0;
        CFO_valid_i      = 1'b0;
    endtask

    task automatic load_inc(input logic [19:0] inc);
        CFO_DDS_inc_i = inc;
        CFO_valid_i   = 1'b1;
        @(negedge clk_i);
        CFO_valid_i   = 1'b0;
    endtask

    // Monitor: pops and compares on every valid output, including latency.
    initial begin
        exp_t e;
        int   re_o;
        int   im_o;
        forever begin
            @(negedge clk_i);
            if (m_axis_out_tvalid) begin
                re_o = int'($signed(m_axis_out_tdata[15:0]));
                im_o = int'($signed(m_axis_out_tdata[31:16]));
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got re=%0d im=%0d, expected no output", re_o, im_o);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_re"}, re_o, e.re, 2);
                    check({e.name, "_im"}, im_o, e.im, 2);
                    check({e.name, "_lat"}, cyc - e.edge_n, 4, 0);
                end
            end
        end
    end

    initial begin
        int qb;
        reset_i          = 1'b1;
        s_axis_in_tdata  = '0;
        s_axis_in_tvalid = 1'b0;
        CFO_DDS_inc_i    = '0;
        CFO_valid_i      = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_valid", m_axis_out_tvalid, 0, 0);
        check("rst_data",  m_axis_out_tdata,  0, 0);
        check("rst_phase", phase_o,           0, 0);
        reset_i = 1'b0;
        @(negedge clk_i);

        // 1: zero increment passes the sample through
        for (int i = 0; i < 3; i++) begin
            send(1000, 0, 999, 0, "t1_pass");
        end
        check("t1_phase", phase_o, 0, 0);
        repeat (2) @(negedge clk_i);

        // 2: +pi/2 per sample, with one idle gap
        load_inc(20'h40000);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) @(negedge clk_i);
            send(8192, 0, q_re[i % 4], q_im[i % 4], "t2_pi2");
            check("t2_phase", phase_o, ((i + 1) * 32'h40000) & 32'hFFFFF, 0);
        end

        // 3: -pi/2 per sample, accumulator wraps downward
        load_inc(20'hC0000);
        for (int i = 0; i < 4; i++) begin
            send(8192, 0, q_re[(4 - i) % 4], q_im[(4 - i) % 4], "t3_mpi2");
            check("t3_phase", phase_o, ((3 * (i + 1)) % 4) * 32'h40000, 0);
        end

        // 4: strobe on the same edge as a sample
        load_inc(20'h00000);
        CFO_DDS_inc_i = 20'h40000;
        CFO_valid_i   = 1'b1;
        send(8192, 0, 8191, 0, "t4_same_edge");
        check("t4_phase_a", phase_o, 0, 0);
        send(8192, 0, 8191, 0, "t4_next");
        check("t4_phase_b", phase_o, 32'h40000, 0);
        send(8192, 0, 0, -8192, "t4_after");
        check("t4_phase_c", phase_o, 32'h80000, 0);

        // 4b: increment update alone, phase continuity vs restart
        load_inc(20'h00000);
`ifdef CFO_CORR_PHASE_RESET_EN
        check("t4b_phase", phase_o, 0, 0);
        send(8192, 0, 8191, 0, "t4b_restart");
        qb = 0;
`else
        check("t4b_phase", phase_o, 32'h80000, 0);
        send(8192, 0, -8192, 0, "t4b_cont");
        qb = 2;
`endif

        // 6: asynchronous reset mid-stream drops in-flight samples
        load_inc(20'h40000);
        for (int i = 0; i < 5; i++) begin
            send(8192, 0, q_re[(qb + i) % 4], q_im[(qb + i) % 4], "t6_pre");
        end
        #1;
        check("t6_valid_before", m_axis_out_tvalid, 1, 0);
        #1;
        reset_i = 1'b1;
        #1;
        check("t6_async_valid", m_axis_out_tvalid, 0, 0);
        check("t6_async_data",  m_axis_out_tdata,  0, 0);
        check("t6_async_phase", phase_o,           0, 0);
        exp_q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        send(8192, 0, 8191, 0, "t6_post_first");
        send(8192, 0, 8191, 0, "t6_post_second");
        check("t6_post_phase", phase_o, 0, 0);

        // 5: pi/4 rotation of a full-scale sample saturates re.
        // Second sample: s = LUT[128] = 23170, c = LUT[127] = 23027, so
        // re = 32767*46197>>15 = 46195 -> 32767, im = 32767*(-143)>>15 = -143.
        load_inc(20'h20000);
        send(32767, 32767, 32765, 32765, "t5_first");
        send(32767, 32767, 32767, -143, "t5_second");
        check("t5_phase", phase_o, 32'h40000, 0);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(negedge clk_i);
        end
        check("drain", exp_q.size(), 0, 0);
        repeat (4) @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
